// File: rtl/alu_sched_pkg.sv
// Shared definitions for the alu_sched scheduler: opcodes, FSM states and the ALU function.
// Optional urgent-priority arbitration is enabled by defining ALU_SCHED_URGENT_EN.
package alu_sched_pkg;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_NOT_A = 2'b10;
  localparam logic [1:0] OP_ROR_B = 2'b11;

  localparam int RES_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Operands are sign-extended to RES_W bits first, so add/sub cannot overflow.
  function automatic logic [RES_W-1:0] alu_compute(
    input logic [1:0] op,
    input logic [3:0] a,
    input logic [3:0] b
  );
    logic [RES_W-1:0] sa;
    logic [RES_W-1:0] sb;
    logic [RES_W-1:0] res;
    sa = {a[3], a};
    sb = {b[3], b};
    case (op)
      OP_ADD:   res = sa + sb;
      OP_SUB:   res = sa - sb;
      OP_NOT_A: res = ~sa;
      OP_ROR_B: res = (b != 4'd0) ? 5'd1 : 5'd0;
      default:  res = 5'd0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_sched_alu_rr_arb.sv
// Combinational round-robin picker: first set request at or above i_ptr, with wrap.
// The pointer itself is owned by the instantiating scheduler.
module alu_rr_arb #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_ptr,
  output logic [N-1:0]   o_grant,
  output logic [IDW-1:0] o_idx,
  output logic           o_any
);

  // Scan N positions starting at i_ptr; only the first hit is recorded.
  always_comb begin
    int   j;
    logic w_hit;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    j       = 0;
    w_hit   = 1'b0;
    for (int k = 0; k < N; k++) begin
      j          = int'(i_ptr) + k;
      j          = (j >= N) ? (j - N) : j;
      w_hit      = !o_any && i_req[j];
      o_grant[j] = o_grant[j] | w_hit;
      o_idx      = w_hit ? IDW'(j) : o_idx;
      o_any      = o_any | w_hit;
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Shared-ALU scheduler: round-robin grant of NUM_REQ requesters onto one 4-bit ALU,
// tagged result on a valid/ready channel. Define ALU_SCHED_URGENT_EN for urgent priority.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [2*NUM_REQ-1:0] req_opcode,
  input  logic [4*NUM_REQ-1:0] req_a,
  input  logic [4*NUM_REQ-1:0] req_b,
`ifdef ALU_SCHED_URGENT_EN
  input  logic [NUM_REQ-1:0]   req_urgent,
`endif
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [RES_W-1:0]     rsp_data
);

  state_e           r_state;
  logic [ID_W-1:0]  r_ptr;
  logic [1:0]       r_op;
  logic [3:0]       r_a;
  logic [3:0]       r_b;
  logic [ID_W-1:0]  r_id;
  logic             r_rsp_valid;
  logic [ID_W-1:0]  r_rsp_id;
  logic [RES_W-1:0] r_rsp_data;

  logic [NUM_REQ-1:0] w_cand;
  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_idx;
  logic [ID_W-1:0]    w_ptr_nxt;
  logic               w_any;
  logic               w_go;
  logic               w_take;

`ifdef ALU_SCHED_URGENT_EN
  logic [NUM_REQ-1:0] w_urg;
  assign w_urg  = req_valid & req_urgent;
  assign w_cand = (|w_urg) ? w_urg : req_valid;
`else
  assign w_cand = req_valid;
`endif

  alu_rr_arb #(
    .N   (NUM_REQ),
    .IDW (ID_W)
  ) u_arb (
    .i_req   (w_cand),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // Gating with reset keeps req_ready low while reset is held, independent of the clock.
  assign w_go      = reset && ((r_state == IDLE) || ((r_state == RESP) && rsp_ready));
  assign w_take    = w_go && w_any;
  assign req_ready = w_go ? w_grant : {NUM_REQ{1'b0}};
  assign w_ptr_nxt = (w_idx == ID_W'(NUM_REQ - 1)) ? {ID_W{1'b0}} : (w_idx + ID_W'(1));

  // Scheduler FSM with the operand latch and the registered response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_op        <= 2'b00;
      r_a         <= 4'd0;
      r_b         <= 4'd0;
      r_id        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
    end else begin
      if (w_take) begin
        r_op  <= req_opcode[2*int'(w_idx) +: 2];
        r_a   <= req_a[4*int'(w_idx) +: 4];
        r_b   <= req_b[4*int'(w_idx) +: 4];
        r_id  <= w_idx;
        r_ptr <= w_ptr_nxt;
      end
      case (r_state)
        IDLE: begin
          r_state <= w_take ? EXEC : IDLE;
        end
        EXEC: begin
          r_rsp_data  <= alu_compute(r_op, r_a, r_b);
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= w_take ? EXEC : IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;

endmodule

// File: doc/alu_sched.md
# alu_sched

Shared-ALU scheduler: arbitrates NUM_REQ requesters onto one 4-bit signed add/sub/not/reduce-OR execution stage and returns each tagged result through a valid/ready response channel. Grants are round-robin among asserted requests. The block sits between the requester-side issue logic and result consumers. Throughput is one operation per two cycles under continuous load.

## Interface
- NUM_REQ, 4: number of requesters, 2..8
- ID_W, $clog2(NUM_REQ): width of the requester tag (localparam, not overridable)
- clk  input  1  single clock; all state on rising edge
- reset  input  1  asynchronous, active-low reset
- req_valid  input  NUM_REQ  per-requester request valid
- req_opcode  input  2*NUM_REQ  per-requester opcode, slice i = [2i+1:2i]
- req_a  input  4*NUM_REQ  signed 2's-complement operand A, slice i = [4i+3:4i]
- req_b  input  4*NUM_REQ  signed 2's-complement operand B, same slicing
- req_ready  output  NUM_REQ  one-hot grant; request i accepted when req_valid[i] && req_ready[i]
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer accepts result
- rsp_id  output  ID_W  index of the requester that issued the result
- rsp_data  output  5  signed 2's-complement result

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state: IDLE.
- Grant opportunity (GO) occurs in IDLE, or in RESP when rsp_ready=1.
- In a GO cycle with any req_valid set, req_ready is the one-hot of the winner. The block latches its opcode, A, B and id, then enters EXEC. Otherwise req_ready=0.
- Arbitration is round-robin: search upward from ptr with wrap, first set req_valid wins. On a grant to i, ptr <= (i+1) mod NUM_REQ. Without a grant, ptr holds.
- EXEC: compute the result, register it into rsp_data/rsp_id, go to RESP.
- RESP: rsp_valid=1 and rsp_data/rsp_id are held stable. On rsp_ready=1, go to EXEC if a grant occurs in the same cycle, else to IDLE.
- Opcode 00 is A+B, 01 is A-B, 10 is ~A, 11 is |B. Operands are sign-extended to 5 bits, so add and sub never overflow; the range is -16..15. ~A is the 5-bit inverse of sext(A), which equals -A-1. |B is 5'd1 if B!=0, else 5'd0.
- Requesters must hold req_valid and operands stable until granted. req_ready is combinational from req_valid, state, ptr and rsp_ready.

## Timing
- Reset values: state IDLE, ptr 0, rsp_valid 0, rsp_id 0, rsp_data 0, req_ready 0.
- Latency: grant in cycle T, rsp_valid first high in cycle T+2.
- Back-to-back: a response accepted in cycle T together with a new grant gives the next rsp_valid in cycle T+2.
- rsp_ready=0 stalls indefinitely. req_ready stays 0 throughout EXEC and stalled RESP.
- Simultaneous requests: exactly one grant per GO cycle, never two.
- Single requester continuously valid: granted at every GO.
- Reset asserted mid-operation: the in-flight op is discarded and outputs return to reset values immediately, without waiting for clk.

## Configuration
- ALU_SCHED_URGENT_EN defined: adds port req_urgent, input, NUM_REQ bits.
  - At a GO, if any (req_valid & req_urgent) bit is set, the round-robin search runs over that subset only. Otherwise it runs over req_valid.
  - ptr updates identically in both cases.
- ALU_SCHED_URGENT_EN undefined: the port is absent and pure round-robin applies.

## Structure
- Shared package alu_sched_pkg holds:
  - the opcode localparams OP_ADD=2'b00, OP_SUB=2'b01, OP_NOT_A=2'b10, OP_ROR_B=2'b11
  - the FSM state enum {IDLE, EXEC, RESP}
  - the result width constant RES_W=5
- Sub-module alu_rr_arb: a combinational round-robin picker. Inputs are the request vector and ptr; outputs are the one-hot grant and the encoded index. ptr is owned by alu_sched.

## Test plan
- Reset, then one request: req 2 issues op 00 with A=7, B=7 while rsp_ready=1. Expect req_ready=4'b0100 and, 2 cycles later, rsp_valid=1, rsp_id=2, rsp_data=14.
- Arithmetic corners:
  - A=-8, B=-8, op 00 gives -16.
  - A=7, B=-8, op 01 gives 15.
  - A=-8, op 10 gives 7.
  - B=0, op 11 gives 0; B=-1, op 11 gives 1.
- Fairness: all 4 requesters held valid, rsp_ready=1. Expect grant order 0,1,2,3,0 and rsp_valid high every other cycle.
- Backpressure: rsp_ready=0 for 5 cycles in RESP. rsp_data and rsp_id must stay constant and req_ready must stay 0. On release, the next grant and acceptance occur in the same cycle.
- Reset mid-EXEC: drive reset low. rsp_valid and req_ready go to 0 immediately, and after release the first grant goes to requester 0.
- With ALU_SCHED_URGENT_EN: reqs 0 and 3 valid, urgent[3]=1, ptr=0. Expect a grant to 3, then a grant to 0 at the next GO if urgent is cleared.
